alu_core: RTL and testbench

- Registered W-bit arithmetic/logic unit. Performs one of eight operations on operands A and B, selected by a 3-bit opcode `sel`.
- The result and status flags are registered one clock after an accepted request.
- Used as the datapath execution unit; the downstream consumer samples `result` and the flags when `out_valid` is high.

---
 rtl/alu_core.sv | 94 +++++++++
 tb/tb_alu_core.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered eight-operation ALU with carry/overflow/zero/negative flags
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  // One extra bit on each side exposes carry-out (ADD) and borrow (SUB).
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_overflow;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};

  // Next result and flags for the current opcode; logic ops leave carry/overflow at 0.
  always_comb begin
    nxt_result   = '0;
    nxt_carry    = 1'b0;
    nxt_overflow = 1'b0;
    case (op_e'(sel))
      OP_ADD: begin
        nxt_result   = add_full[WIDTH-1:0];
        nxt_carry    = add_full[WIDTH];
        nxt_overflow = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB: begin
        nxt_result   = sub_full[WIDTH-1:0];
        nxt_carry    = sub_full[WIDTH];
        nxt_overflow = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
      end
      OP_AND: nxt_result = A & B;
      OP_OR:  nxt_result = A | B;
      OP_NOT: nxt_result = ~A;
      OP_XOR: nxt_result = A ^ B;
      OP_SHL: begin
        nxt_result = {A[WIDTH-2:0], 1'b0};
        nxt_carry  = A[MSB];
      end
      OP_SHR: begin
        nxt_result = {1'b0, A[WIDTH-1:1]};
        nxt_carry  = A[0];
      end
    endcase
  end

  // Capture on accepted requests; zero/negative are registered so reset drives them to 0 too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= nxt_result;
        carry    <= nxt_carry;
        overflow <= nxt_overflow;
        zero     <= (nxt_result == '0);
        negative <= nxt_result[MSB];
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed self-checking bench for alu_core
module tb_alu_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] sel;
  logic [3:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;
  logic       out_valid;

  int checks;
  int errors;

  alu_core #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .sel       (sel),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {result[3:0], carry, overflow, zero, negative, out_valid}
  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {result, carry, overflow, zero, negative, out_valid};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (res c v z n ov)", tag, obs, exp);
    end
  endtask

  // Apply one request (or idle when iv=0), step one edge, then sample 1 time unit later.
  task automatic step(input logic iv, input logic [3:0] av, input logic [3:0] bv, input logic [2:0] sv);
    in_valid = iv;
    a = av;
    b = bv;
    sel = sv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'h0;
    b        = 4'h0;
    sel      = 3'b000;

    // Reset held while inputs toggle: outputs stay 0
    step(1'b1, 4'b0111, 4'b0001, 3'b000);
    step(1'b1, 4'b1111, 4'b1111, 3'b100);
    step(1'b1, 4'b0001, 4'b0010, 3'b001);
    check("reset_hold", 9'b0000_0_0_0_0_0);

    // Release between edges with a request present; first edge accepts it
    in_valid = 1'b1; a = 4'b0011; b = 4'b0001; sel = 3'b000;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("add_0011_0001", 9'b0100_0_0_0_0_1);

    step(1'b1, 4'b1111, 4'b0001, 3'b000);
    check("add_wrap_zero", 9'b0000_1_0_1_0_1);
    step(1'b1, 4'b0111, 4'b0001, 3'b000);
    check("add_overflow", 9'b1000_0_1_0_1_1);

    step(1'b1, 4'b0110, 4'b0011, 3'b001);
    check("sub_0110_0011", 9'b0011_0_0_0_0_1);
    step(1'b1, 4'b0001, 4'b0010, 3'b001);
    check("sub_borrow", 9'b1111_1_0_0_1_1);
    step(1'b1, 4'b1000, 4'b0001, 3'b001);
    check("sub_overflow", 9'b0111_0_1_0_0_1);

    step(1'b1, 4'b1010, 4'b1100, 3'b010);
    check("and", 9'b1000_0_0_0_1_1);
    step(1'b1, 4'b1010, 4'b0101, 3'b011);
    check("or", 9'b1111_0_0_0_1_1);
    step(1'b1, 4'b1111, 4'b0000, 3'b100);
    check("not_zero", 9'b0000_0_0_1_0_1);
    step(1'b1, 4'b1010, 4'b0110, 3'b101);
    check("xor", 9'b1100_0_0_0_1_1);
    step(1'b1, 4'b0000, 4'b1010, 3'b100);
    check("not_ignores_b", 9'b1111_0_0_0_1_1);

    step(1'b1, 4'b1001, 4'b1111, 3'b110);
    check("shl", 9'b0010_1_0_0_0_1);
    step(1'b1, 4'b1001, 4'b0110, 3'b111);
    check("shr", 9'b0100_1_0_0_0_1);
    step(1'b1, 4'b0110, 4'b0000, 3'b111);
    check("shr_carry0", 9'b0011_0_0_0_0_1);
    step(1'b1, 4'b1001, 4'b1001, 3'b101);
    check("xor_clears_carry", 9'b0000_0_0_1_0_1);

    // Three back-to-back requests, then idle cycles hold the last result
    step(1'b1, 4'b0010, 4'b0011, 3'b000);
    check("b2b_1_add", 9'b0101_0_0_0_0_1);
    step(1'b1, 4'b0101, 4'b0001, 3'b001);
    check("b2b_2_sub", 9'b0100_0_0_0_0_1);
    step(1'b1, 4'b0001, 4'b0010, 3'b011);
    check("b2b_3_or", 9'b0011_0_0_0_0_1);
    step(1'b0, 4'b1111, 4'b1111, 3'b000);
    check("idle_hold_1", 9'b0011_0_0_0_0_0);
    step(1'b0, 4'b0111, 4'b0001, 3'b000);
    check("idle_hold_2", 9'b0011_0_0_0_0_0);

    // Asynchronous reset between edges clears outputs immediately
    step(1'b1, 4'b0111, 4'b0001, 3'b000);
    check("pre_async", 9'b1000_0_1_0_1_1);
    in_valid = 1'b1; a = 4'b1111; b = 4'b0001; sel = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", 9'b0000_0_0_0_0_0);

    // Request pending across an edge in reset is discarded; no pulse after release
    @(posedge clk); #1;
    check("reset_discard", 9'b0000_0_0_0_0_0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_pulse_after_release", 9'b0000_0_0_0_0_0);

    step(1'b1, 4'b1000, 4'b1000, 3'b000);
    check("add_neg_overflow", 9'b0000_1_1_1_0_1);
    step(1'b0, 4'b0000, 4'b0000, 3'b000);
    check("final_idle", 9'b0000_1_1_1_0_0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
